dec_keypad_bcd_encoder: RTL and testbench
=========================================

# dec_keypad_bcd_encoder

Sequential decimal-to-BCD encoder, the encode side of the existing BCD-to-decimal decoder. It accepts ten active-high decimal key lines (one-hot, asynchronous to the clock, bouncy) and synchronizes and debounces them. Each debounced press is encoded to a 4-bit BCD digit and shifted into a multi-digit BCD entry register. It sits between a front-panel keypad and the display/decoder path: `bcd_out` digits feed the decoder directly.

## Interface
- `DIGITS`, 4: number of BCD digits held in the entry register (1..8).
- `DEBOUNCE`, 4: consecutive identical synchronized samples required to accept a press or a release (2..255).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `key_in`  in  10: decimal key lines, bit k = digit k. Asynchronous.
- `clear`  in  1: synchronous clear of the entry register, `digit_count` and `overflow`.
- `bcd_code`  out  4: BCD code of the last accepted key.
- `digit_valid`  out  1: one-cycle pulse; a digit was accepted this cycle.
- `key_error`  out  1: one-cycle pulse; a debounced multi-hot key pattern was rejected.
- `bcd_out`  out  4*DIGITS: entry register; digit 0 (bits 3:0) is the newest.
- `digit_count`  out  4: digits entered, saturating at DIGITS.
- `overflow`  out  1: sticky; a digit was shifted out of the top of `bcd_out`.

## Operation
- Reset values: all outputs 0, FSM IDLE, sync flops 0, counter 0.
- `key_in` passes through a 2-flop synchronizer to give `key_s`. The FSM uses only `key_s`.
- FSM states:
  - IDLE:
    - `key_s`==0: stay.
    - Otherwise: latch `key_s` into `key_l`, cnt=1, go to CHECK.
  - CHECK:
    - `key_s`==`key_l`: cnt++.
    - `key_s`==0: go to IDLE.
    - `key_s` is another nonzero value: relatch, cnt=1.
    - On the edge where `key_s`==`key_l` and cnt==DEBOUNCE-1: accept and go to HELD.
  - HELD: wait for `key_s`==0 on DEBOUNCE consecutive samples, then go to IDLE. Any nonzero sample restarts the release count. No new press is accepted in HELD.
- Accept, when `key_l` is one-hot:
  - `bcd_code`=index of the set bit (0..9). `digit_valid`=1 for one cycle.
  - `bcd_out` shifts left by 4 and `bcd_code` is inserted into digit 0.
  - `digit_count` increments, saturating at DIGITS.
  - If `digit_count` was already DIGITS, the top digit is lost and `overflow` is set.
- Accept, when `key_l` is multi-hot: `key_error`=1 for one cycle. `bcd_code`, `bcd_out` and `digit_count` are unchanged. Go to HELD.
- `clear` in the same cycle as an accept: clear wins. `bcd_out`=0, `digit_count`=0, `overflow`=0. `digit_valid`/`bcd_code` still report the digit, but it is not stored. The FSM is unaffected by `clear`.
- Reset mid-press: everything returns to reset values immediately. A key still held after reset release is treated as a new press.

## Timing
- `key_in` changes before edge 1 and is held stable:
  - `key_s` updates at edge 2.
  - IDLE→CHECK at edge 3.
  - Accept at edge DEBOUNCE+2. `digit_valid`/`key_error` are high for the following cycle.
  - With DEBOUNCE=4: accept at edge 6.
- Release: after `key_in` goes to 0, the FSM reaches IDLE DEBOUNCE+2 edges later. A new press can be accepted DEBOUNCE+2 edges after that at the earliest.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Package `dec_bcd_pkg`:
  - FSM state encodings: IDLE=2'd0, CHECK=2'd1, HELD=2'd2.
  - Function `onehot10_to_bcd` returning {valid, code[3:0]}. valid=0 for zero or multi-hot inputs.
- Sub-module `sync_2ff` (width parameter), used for `key_in`. Everything else is in one module.

## Test plan
- Reset: with `rst_n`=0 and `key_in`=10'h3FF, all outputs stay 0. Release reset with keys still held → one `key_error`, no `digit_valid`.
- Press key 7 (`key_in`=10'h080) held for 10 cycles, DEBOUNCE=4 → `digit_valid` pulses once after edge 6, `bcd_code`=4'h7, `bcd_out`=16'h0007, `digit_count`=1.
- Bounce: key 3 toggling every 2 cycles for 8 cycles, then stable → no accept during the bounce. Exactly one `digit_valid` with code 3 after the line is stable for DEBOUNCE+2 edges.
- Enter 1,2,3,4,5 (DIGITS=4) with full releases between presses → `bcd_out`=16'h2345, `digit_count`=4, `overflow`=1. A later `clear` → all 0.
- Multi-hot `key_in`=10'h011 held → one `key_error` pulse, `bcd_out` unchanged. Key 9 held without release → exactly one accept.
- `clear` asserted on the accept edge of key 5 → `digit_valid`=1, `bcd_code`=5, `bcd_out`=0, `digit_count`=0.

Source files
------------

// File: rtl/dec_keypad_bcd_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dec_bcd_pkg
// Description : Shared FSM encodings and the one-hot-to-BCD helper used by
//               the keypad BCD encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package dec_bcd_pkg;

   // Debounce FSM state encodings
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CHECK = 2'd1;
   localparam logic [1:0] HELD  = 2'd2;

   // Width of the debounce sample counter; covers DEBOUNCE up to 255
   localparam int CNT_W = 8;

   // Returns {valid, code}. valid is set only when exactly one key line is
   // active; zero and multi-hot patterns return all zeros.
   function automatic logic [4:0] onehot10_to_bcd(input logic [9:0] keys);
      logic [3:0] code;
      logic [3:0] ones;
      code = 4'd0;
      ones = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (keys[i]) begin
            ones = ones + 4'd1;
            code = 4'(i);
         end
      end
      return (ones == 4'd1) ? {1'b1, code} : 5'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dec_keypad_bcd_encoder_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer bank for asynchronous level inputs.
//               Each bit is synchronized independently.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] meta_d;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] sync_d;

   // First stage samples the raw input, second stage resolves metastability
   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
   end

   // Synchronizer flops, cleared by the asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q;

endmodule
`default_nettype wire

// File: rtl/dec_keypad_bcd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : dec_keypad_bcd_encoder
// Description : Synchronizes and debounces ten decimal key lines, encodes
//               each accepted press to BCD and shifts it into a multi-digit
//               entry register. Multi-hot presses are reported as errors.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_keypad_bcd_encoder
   import dec_bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int DEBOUNCE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [9:0]            key_in,
   input  logic                  clear,
   output logic [3:0]            bcd_code,
   output logic                  digit_valid,
   output logic                  key_error,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [3:0]            digit_count,
   output logic                  overflow
);

   // Last sample index: a press or release is accepted on the DEBOUNCE-th
   // consecutive identical sample.
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE - 1);
   localparam logic [3:0]       c_digits   = 4'(DIGITS);

   logic [9:0]          key_s;

   logic [1:0]          state_q;
   logic [1:0]          state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [9:0]          key_l_q;
   logic [9:0]          key_l_d;
   logic                accept;

   logic [3:0]          bcd_code_q;
   logic [3:0]          bcd_code_d;
   logic                digit_valid_q;
   logic                digit_valid_d;
   logic                key_error_q;
   logic                key_error_d;
   logic [4*DIGITS-1:0] bcd_out_q;
   logic [4*DIGITS-1:0] bcd_out_d;
   logic [3:0]          digit_count_q;
   logic [3:0]          digit_count_d;
   logic                overflow_q;
   logic                overflow_d;

   logic [4:0]          key_dec;
   logic [4*DIGITS-1:0] bcd_shifted;

   sync_2ff #(
      .WIDTH    (10)
   ) u_key_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (key_in),
      .sync_out (key_s)
   );

   // Decode of the latched pattern; only consulted on the accept cycle
   always_comb begin
      key_dec = onehot10_to_bcd(key_l_q);
   end

   // Entry register shifted by one digit with the new code in digit 0
   if (DIGITS == 1) begin : g_shift_single
      assign bcd_shifted = key_dec[3:0];
   end else begin : g_shift_multi
      assign bcd_shifted = {bcd_out_q[4*DIGITS-5:0], key_dec[3:0]};
   end

   // State register plus all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         key_l_q       <= '0;
         bcd_code_q    <= '0;
         digit_valid_q <= 1'b0;
         key_error_q   <= 1'b0;
         bcd_out_q     <= '0;
         digit_count_q <= '0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         key_l_q       <= key_l_d;
         bcd_code_q    <= bcd_code_d;
         digit_valid_q <= digit_valid_d;
         key_error_q   <= key_error_d;
         bcd_out_q     <= bcd_out_d;
         digit_count_q <= digit_count_d;
         overflow_q    <= overflow_d;
      end
   end

   // Debounce FSM next-state: qualify a stable press, then wait for a stable release
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_l_d = key_l_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (key_s != 10'd0) begin
               key_l_d = key_s;
               cnt_d   = CNT_W'(1);
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (key_s == 10'd0) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (key_s == key_l_q) begin
               if (cnt_q == c_cnt_last) begin
                  accept  = 1'b1;
                  cnt_d   = '0;
                  state_d = HELD;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               // A different pattern restarts qualification from scratch
               key_l_d = key_s;
               cnt_d   = CNT_W'(1);
            end
         end
         HELD: begin
            if (key_s == 10'd0) begin
               if (cnt_q == c_cnt_last) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               cnt_d = '0;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Output/datapath: encode the accepted key, update the entry register; clear has priority over storage
   always_comb begin
      bcd_code_d    = bcd_code_q;
      digit_valid_d = 1'b0;
      key_error_d   = 1'b0;
      bcd_out_d     = bcd_out_q;
      digit_count_d = digit_count_q;
      overflow_d    = overflow_q;
      if (accept) begin
         if (key_dec[4]) begin
            bcd_code_d    = key_dec[3:0];
            digit_valid_d = 1'b1;
            bcd_out_d     = bcd_shifted;
            if (digit_count_q >= c_digits) begin
               overflow_d = 1'b1;
            end else begin
               digit_count_d = digit_count_q + 4'd1;
            end
         end else begin
            key_error_d = 1'b1;
         end
      end
      if (clear) begin
         bcd_out_d     = '0;
         digit_count_d = '0;
         overflow_d    = 1'b0;
      end
   end

   assign bcd_code    = bcd_code_q;
   assign digit_valid = digit_valid_q;
   assign key_error   = key_error_q;
   assign bcd_out     = bcd_out_q;
   assign digit_count = digit_count_q;
   assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_keypad_bcd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec_keypad_bcd_encoder
// Description : Directed self-checking bench for the keypad BCD encoder
//               (DIGITS=4, DEBOUNCE=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec_keypad_bcd_encoder;

   localparam int DIGITS   = 4;
   localparam int DEBOUNCE = 4;

   logic        clk;
   logic        rst_n;
   logic [9:0]  key_in;
   logic        clear;
   logic [3:0]  bcd_code;
   logic        digit_valid;
   logic        key_error;
   logic [15:0] bcd_out;
   logic [3:0]  digit_count;
   logic        overflow;

   int n_tests;
   int n_fail;
   int dv_total;
   int ke_total;

   typedef struct {
      logic [9:0]  key;
      logic [3:0]  code;
      logic [15:0] bcd;
      logic [3:0]  cnt;
      logic        ovf;
      int          dv;
      int          ke;
   } vec_t;

   vec_t vecs[7];

   dec_keypad_bcd_encoder #(
      .DIGITS      (DIGITS),
      .DEBOUNCE    (DEBOUNCE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .clear       (clear),
      .bcd_code    (bcd_code),
      .digit_valid (digit_valid),
      .key_error   (key_error),
      .bcd_out     (bcd_out),
      .digit_count (digit_count),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Running totals of output pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (digit_valid) dv_total = dv_total + 1;
      if (key_error)   ke_total = ke_total + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Press, hold, release, and wait long enough for the FSM to return to IDLE
   task automatic press_release(input logic [9:0] k, input int hold);
      @(posedge clk); #1;
      key_in = k;
      cycles(hold);
      key_in = 10'd0;
      cycles(2 * DEBOUNCE + 6);
      @(negedge clk);
   endtask

   task automatic check_regs(input string tag, input logic [15:0] b, input logic [3:0] c, input logic o);
      check({tag, "_bcd_out"}, 32'(bcd_out), 32'(b));
      check({tag, "_count"},   32'(digit_count), 32'(c));
      check({tag, "_overflow"}, 32'(overflow), 32'(o));
   endtask

   initial begin
      int dv0;
      int ke0;
      n_tests  = 0;
      n_fail   = 0;
      dv_total = 0;
      ke_total = 0;

      vecs[0] = '{10'h002, 4'h1, 16'h0001, 4'd1, 1'b0, 1, 0};
      vecs[1] = '{10'h004, 4'h2, 16'h0012, 4'd2, 1'b0, 1, 0};
      vecs[2] = '{10'h008, 4'h3, 16'h0123, 4'd3, 1'b0, 1, 0};
      vecs[3] = '{10'h010, 4'h4, 16'h1234, 4'd4, 1'b0, 1, 0};
      vecs[4] = '{10'h020, 4'h5, 16'h2345, 4'd4, 1'b1, 1, 0};
      vecs[5] = '{10'h011, 4'h5, 16'h2345, 4'd4, 1'b1, 0, 1};
      vecs[6] = '{10'h001, 4'h0, 16'h3450, 4'd4, 1'b1, 1, 0};

      // Reset held with every key pressed: all outputs stay zero
      rst_n  = 1'b0;
      key_in = 10'h3FF;
      clear  = 1'b0;
      repeat (6) @(negedge clk);
      check("reset_outputs", {10'd0, bcd_code, digit_valid, key_error, bcd_out},  32'd0);
      check("reset_count_ovf", {27'd0, digit_count, overflow}, 32'd0);

      // Release reset with keys still held: one multi-hot rejection
      dv0 = dv_total; ke0 = ke_total;
      @(posedge clk); #2;
      rst_n = 1'b1;
      cycles(14);
      check("rst_release_key_error", 32'(ke_total - ke0), 32'd1);
      check("rst_release_no_digit",  32'(dv_total - dv0), 32'd0);
      key_in = 10'd0;
      cycles(2 * DEBOUNCE + 6);

      // Key 7: accept lands on edge DEBOUNCE+2, pulse visible for one cycle
      @(posedge clk); #1;
      key_in = 10'h080;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("key7_dv_edge%0d", e), 32'(digit_valid), (e == DEBOUNCE + 2) ? 32'd1 : 32'd0);
      end
      check("key7_code", 32'(bcd_code), 32'h7);
      check_regs("key7", 16'h0007, 4'd1, 1'b0);
      key_in = 10'd0;
      cycles(2 * DEBOUNCE + 6);

      // Key 3 bouncing every 2 cycles: nothing accepted until stable
      dv0 = dv_total;
      @(posedge clk); #1;
      for (int b = 0; b < 4; b++) begin
         key_in = (b % 2 == 0) ? 10'h008 : 10'h000;
         cycles(2);
      end
      cycles(DEBOUNCE + 2);
      check("bounce_no_accept", 32'(dv_total - dv0), 32'd0);
      key_in = 10'h008;
      cycles(DEBOUNCE + 4);
      @(negedge clk);
      check("bounce_one_accept", 32'(dv_total - dv0), 32'd1);
      check("bounce_code", 32'(bcd_code), 32'h3);
      check_regs("bounce", 16'h0073, 4'd2, 1'b0);
      key_in = 10'd0;
      cycles(2 * DEBOUNCE + 6);

      // Clear the entry register before the table run
      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
      @(negedge clk);
      check_regs("clear1", 16'h0000, 4'd0, 1'b0);

      // Table: digits 1..5 overflow a 4-digit register, then multi-hot, then 0
      for (int i = 0; i < 7; i++) begin
         dv0 = dv_total; ke0 = ke_total;
         press_release(vecs[i].key, 10);
         check($sformatf("vec%0d_dv", i), 32'(dv_total - dv0), 32'(vecs[i].dv));
         check($sformatf("vec%0d_ke", i), 32'(ke_total - ke0), 32'(vecs[i].ke));
         check($sformatf("vec%0d_code", i), 32'(bcd_code), 32'(vecs[i].code));
         check_regs($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].cnt, vecs[i].ovf);
      end

      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
      @(negedge clk);
      check_regs("clear2", 16'h0000, 4'd0, 1'b0);

      // Key 9 held for a long time: a single accept only
      dv0 = dv_total;
      @(posedge clk); #1;
      key_in = 10'h200;
      cycles(40);
      check("key9_held_one_accept", 32'(dv_total - dv0), 32'd1);
      check("key9_code", 32'(bcd_code), 32'h9);
      check_regs("key9", 16'h0009, 4'd1, 1'b0);
      key_in = 10'd0;
      cycles(2 * DEBOUNCE + 6);

      // Clear coincident with the key-5 accept edge: reported but not stored
      @(posedge clk); #1;
      key_in = 10'h020;
      for (int e = 1; e <= DEBOUNCE + 2; e++) begin
         @(posedge clk);
         if (e == DEBOUNCE + 1) begin
            #1 clear = 1'b1;
         end
      end
      #1 clear = 1'b0;
      @(negedge clk);
      check("clr_acc_dv", 32'(digit_valid), 32'd1);
      check("clr_acc_code", 32'(bcd_code), 32'h5);
      check_regs("clr_acc", 16'h0000, 4'd0, 1'b0);
      key_in = 10'd0;
      cycles(2 * DEBOUNCE + 6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
